vote_worker: RTL and testbench
==============================

Name: vote_worker

Overview:
- Parametrised successor of the partition worker.
- Each batch it takes Q vertex IDs and, per vertex, streams that vertex's adjacency row (D bits) and the neighbour location table W neighbours per cycle. It builds a per-partition neighbour histogram and picks the majority partition.
- Emits one proposal word per batch (target partition + gain per lane, bytemask marking moves) to the proposal SRAM.
- Sits between the vid/dist/loc SRAMs and the proposal SRAM; it adds chunked streaming, stall support, own-location capture and tie rules.

Parameters:
- D, 256, vertices per adjacency row / loc table entries; power of 2
- W, 16, neighbours processed per cycle; divides D; C = D/W chunks
- Q, 16, vertices per batch (lanes)
- VID_BW, 16, vertex ID width
- LOC_BW, 5, loc entry {valid, part[LOC_BW-2:0]}; NPART = 2^(LOC_BW-1)
- PRO_BW, 8, proposal lane {target[LOC_BW-2:0], gain[GBW-1:0]}; GBW = PRO_BW-LOC_BW+1
- BATCH_BW, 8, batch number width
- DIST_ADDR_BW, 16, dist SRAM address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable; low = stall
- start  in  1  batch start pulse; sampled only in IDLE
- batch_num  in  BATCH_BW  batch index; latched on accepted start
- vid_rdata  in  Q*VID_BW  lane q at [q*VID_BW +: VID_BW]; latched on accepted start
- dist_raddr  out  DIST_ADDR_BW  (vid*C + chunk) truncated
- dist_rdata  in  W  bit j = neighbour chunk*W+j; valid 1 cycle after address
- loc_raddr  out  clog2(C)  = chunk
- loc_rdata  in  W*LOC_BW  lane j at [j*LOC_BW +: LOC_BW]; 1-cycle latency
- sub_done  out  1  1-cycle pulse per finished vertex
- pro_wen  out  1  1-cycle write strobe
- pro_waddr  out  BATCH_BW  = latched batch_num
- pro_wdata  out  Q*PRO_BW  lane q result
- pro_bytemask  out  Q  bit q = lane q proposes a move
- batch_finish  out  1  pulse, same cycle as pro_wen
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE. All outputs, histogram, lane regs and counters = 0. Reset mid-batch aborts it with no write.
- FSM: IDLE -> STREAM (accepted start) -> DRAIN -> DECIDE -> STREAM (next vertex) or WRITE (after lane Q-1) -> IDLE.
- start while busy is ignored. start and en low in IDLE: start is still accepted.
- STREAM: drives addresses for current vertex v and chunk c. When en=1, c increments; after c=C-1 go to DRAIN. When en=0, c and addresses hold.
- rd_valid register = (STREAM && en). Returned data is accumulated when rd_valid=1, even if en has since dropped.
- Accumulate: for each lane j with dist bit set, loc valid=1, and neighbour index != vid[log2D-1:0], do count[part]++. Counters are clog2(D+1) bits.
- Own location: captured when the returning chunk == vid[log2D-1:log2W], lane vid[log2W-1:0]. Invalid own entry = no current partition.
- DRAIN: accumulates the final chunk; advances only when en=1.
- DECIDE (en=1, 1 cycle): target selection.
  - target = argmax count.
  - Ties: current partition wins if it is among the maxima; otherwise the lowest index wins.
  - No valid neighbours: target = current (0 if invalid), gain 0, mask 0.
  - gain = count[target] - count[current] (count[current] = 0 if invalid), saturated to 2^GBW-1.
  - mask = valid neighbours exist and (target != current or current invalid).
  - Writes lane regs, clears histogram, pulses sub_done on the next cycle.
  - Moves to the next vertex, or to WRITE after lane Q-1.
- WRITE: pro_wen, batch_finish for exactly 1 cycle; then IDLE.
- Latency, en held 1: start edge to pro_wen = Q*(C+2)+1 cycles (289 at defaults). Each en-low cycle adds 1.
- pro_wdata and pro_bytemask hold their values until the next WRITE.

Test Plan:
- Reset/idle: rst_n low 3 cycles -> all outputs 0, busy 0; start with rst_n low is ignored.
- Majority: vid lane0=5, row 5 has neighbours 0..9 with part 3, 10..12 with part 7; own loc 5 = {1,7} -> lane0 target 3, gain 10-3=7, mask bit 1; pro_wdata[7:0]=0x37.
- Ties: 4 neighbours part 2, 4 part 6, own part 6 -> target 6, gain 0, mask 0. Own part 9 instead -> target 2, gain 4, mask 1.
- Exclusions: self bit set, plus invalid-loc neighbours only -> no counts; target = own, gain 0, mask 0.
- Timing/stall: en=1 throughout -> pro_wen exactly 289 cycles after start, 16 sub_done pulses, pro_waddr = batch_num. Drop en for 5 cycles mid-STREAM -> 294 cycles, identical data.
- Saturation/abort: 255 neighbours in part 1, own part 0 empty -> gain saturates to 15 (0x1F); start during busy is ignored; rst_n pulse at cycle 100 -> no pro_wen, IDLE.

Source files
------------

// File: rtl/vote_worker.sv
// vote_worker: per-batch majority-partition voter. Streams each lane's adjacency row and the
// neighbour location table chunk by chunk, then emits one proposal word per batch.
module vote_worker #(
    parameter int D            = 256,
    parameter int W            = 16,
    parameter int Q            = 16,
    parameter int VID_BW       = 16,
    parameter int LOC_BW       = 5,
    parameter int PRO_BW       = 8,
    parameter int BATCH_BW     = 8,
    parameter int DIST_ADDR_BW = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        start,
    input  logic [BATCH_BW-1:0]         batch_num,
    input  logic [Q*VID_BW-1:0]         vid_rdata,
    output logic [DIST_ADDR_BW-1:0]     dist_raddr,
    input  logic [W-1:0]                dist_rdata,
    output logic [$clog2(D/W)-1:0]      loc_raddr,
    input  logic [W*LOC_BW-1:0]         loc_rdata,
    output logic                        sub_done,
    output logic                        pro_wen,
    output logic [BATCH_BW-1:0]         pro_waddr,
    output logic [Q*PRO_BW-1:0]         pro_wdata,
    output logic [Q-1:0]                pro_bytemask,
    output logic                        batch_finish,
    output logic                        busy
);
    // state   | meaning
    // IDLE    | waiting for start
    // STREAM  | issuing dist/loc reads for the current vertex, one chunk per enabled cycle
    // DRAIN   | last chunk's read data returns and is accumulated
    // DECIDE  | pick target/gain for the current lane, clear histogram
    // WRITE   | one-cycle proposal write, then back to IDLE

    localparam int C      = D / W;
    localparam int CW     = $clog2(C);
    localparam int LD     = $clog2(D);
    localparam int LW     = $clog2(W);
    localparam int PW     = LOC_BW - 1;
    localparam int NPART  = 2 ** PW;
    localparam int GBW    = PRO_BW - LOC_BW + 1;
    localparam int CNT_BW = $clog2(D + 1);
    localparam int QW     = $clog2(Q);
    localparam logic [CNT_BW-1:0] GAIN_MAX = CNT_BW'(2 ** GBW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_DRAIN  = 3'd2,
        S_DECIDE = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t                        state_q;
    logic [QW-1:0]                 v_q;
    logic [CW-1:0]                 chunk_q;
    logic [CW-1:0]                 rd_chunk_q;
    logic                          rd_valid_q;
    logic [Q-1:0][VID_BW-1:0]      vid_q;
    logic [BATCH_BW-1:0]           batch_q;
    logic [NPART-1:0][CNT_BW-1:0]  cnt_q;
    logic [NPART-1:0][CNT_BW-1:0]  cnt_d;
    logic [LOC_BW-1:0]             own_q;
    logic [LOC_BW-1:0]             own_d;
    logic [Q-1:0][PRO_BW-1:0]      lane_q;
    logic [Q-1:0]                  mask_q;
    logic                          sub_done_q;
    logic                          pro_wen_q;
    logic                          batch_finish_q;
    logic [BATCH_BW-1:0]           pro_waddr_q;
    logic [Q*PRO_BW-1:0]           pro_wdata_q;
    logic [Q-1:0]                  pro_bytemask_q;

    logic [VID_BW-1:0]             cur_vid;
    logic [LD-1:0]                 self_idx;
    logic [W-1:0][LOC_BW-1:0]      loc_lane;

    logic [PW-1:0]                 best_part;
    logic [CNT_BW-1:0]             best_cnt;
    logic [CNT_BW-1:0]             own_cnt;
    logic [CNT_BW-1:0]             diff;
    logic [PW-1:0]                 target;
    logic [GBW-1:0]                gain;
    logic                          move;

    assign cur_vid  = vid_q[v_q];
    assign self_idx = cur_vid[LD-1:0];
    assign loc_lane = loc_rdata;

    // vid*C + chunk is a plain concatenation because C is a power of two
    assign dist_raddr   = DIST_ADDR_BW'({cur_vid, chunk_q});
    assign loc_raddr    = chunk_q;
    assign busy         = (state_q != S_IDLE);
    assign sub_done     = sub_done_q;
    assign pro_wen      = pro_wen_q;
    assign batch_finish = batch_finish_q;
    assign pro_waddr    = pro_waddr_q;
    assign pro_wdata    = pro_wdata_q;
    assign pro_bytemask = pro_bytemask_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rd_valid_q) begin
            for (int j = 0; j < W; j++) begin
                if (dist_rdata[j] && loc_lane[j][LOC_BW-1] && ({rd_chunk_q, LW'(j)} != self_idx))
                    cnt_d[loc_lane[j][PW-1:0]] = cnt_d[loc_lane[j][PW-1:0]] + CNT_BW'(1);
            end
        end
    end

    always_comb begin
        own_d = own_q;
        if (rd_valid_q && (rd_chunk_q == self_idx[LD-1:LW]))
            own_d = loc_lane[self_idx[LW-1:0]];
    end

    // Strict '>' keeps the lowest index among equal maxima; own partition overrides on a tie.
    always_comb begin
        best_part = '0;
        best_cnt  = cnt_q[0];
        for (int p = 1; p < NPART; p++) begin
            if (cnt_q[p] > best_cnt) begin
                best_part = PW'(p);
                best_cnt  = cnt_q[p];
            end
        end
        own_cnt = own_q[LOC_BW-1] ? cnt_q[own_q[PW-1:0]] : '0;
        if (own_q[LOC_BW-1] && (own_cnt == best_cnt))
            target = own_q[PW-1:0];
        else
            target = best_part;
        diff = best_cnt - own_cnt;
        gain = (diff > GAIN_MAX) ? '1 : diff[GBW-1:0];
        move = (best_cnt != '0) && (!own_q[LOC_BW-1] || (target != own_q[PW-1:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            v_q            <= '0;
            chunk_q        <= '0;
            rd_chunk_q     <= '0;
            rd_valid_q     <= 1'b0;
            vid_q          <= '0;
            batch_q        <= '0;
            cnt_q          <= '0;
            own_q          <= '0;
            lane_q         <= '0;
            mask_q         <= '0;
            sub_done_q     <= 1'b0;
            pro_wen_q      <= 1'b0;
            batch_finish_q <= 1'b0;
            pro_waddr_q    <= '0;
            pro_wdata_q    <= '0;
            pro_bytemask_q <= '0;
        end else begin
            sub_done_q     <= 1'b0;
            pro_wen_q      <= 1'b0;
            batch_finish_q <= 1'b0;
            rd_valid_q     <= (state_q == S_STREAM) && en;
            rd_chunk_q     <= chunk_q;
            cnt_q          <= cnt_d;
            own_q          <= own_d;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        batch_q <= batch_num;
                        vid_q   <= vid_rdata;
                        v_q     <= '0;
                        chunk_q <= '0;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (en) begin
                        chunk_q <= chunk_q + CW'(1);
                        if (chunk_q == CW'(C - 1))
                            state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (en)
                        state_q <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (en) begin
                        lane_q[v_q] <= {target, gain};
                        mask_q[v_q] <= move;
                        cnt_q       <= '0;
                        own_q       <= '0;
                        sub_done_q  <= 1'b1;
                        if (v_q == QW'(Q - 1)) begin
                            state_q <= S_WRITE;
                        end else begin
                            v_q     <= v_q + QW'(1);
                            state_q <= S_STREAM;
                        end
                    end
                end
                S_WRITE: begin
                    pro_wen_q      <= 1'b1;
                    batch_finish_q <= 1'b1;
                    pro_waddr_q    <= batch_q;
                    pro_wdata_q    <= lane_q;
                    pro_bytemask_q <= mask_q;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_worker.sv
// Bench for vote_worker: lane-0 scenario table with hand-derived results, SRAM models,
// and a scoreboard that checks every proposal write against a reference histogram model.
module tb_vote_worker;
    localparam int D            = 256;
    localparam int W            = 16;
    localparam int C            = D / W;
    localparam int Q            = 16;
    localparam int VID_BW       = 16;
    localparam int LOC_BW       = 5;
    localparam int PRO_BW       = 8;
    localparam int BATCH_BW     = 8;
    localparam int DIST_ADDR_BW = 16;
    localparam int BASE_LAT     = Q * (C + 2) + 1;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      en = 1'b0;
    logic                      start = 1'b0;
    logic [BATCH_BW-1:0]       batch_num = '0;
    logic [Q*VID_BW-1:0]       vid_rdata = '0;
    logic [DIST_ADDR_BW-1:0]   dist_raddr;
    logic [W-1:0]              dist_rdata = '0;
    logic [$clog2(C)-1:0]      loc_raddr;
    logic [W*LOC_BW-1:0]       loc_rdata = '0;
    logic                      sub_done;
    logic                      pro_wen;
    logic [BATCH_BW-1:0]       pro_waddr;
    logic [Q*PRO_BW-1:0]       pro_wdata;
    logic [Q-1:0]              pro_bytemask;
    logic                      batch_finish;
    logic                      busy;

    vote_worker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .start        (start),
        .batch_num    (batch_num),
        .vid_rdata    (vid_rdata),
        .dist_raddr   (dist_raddr),
        .dist_rdata   (dist_rdata),
        .loc_raddr    (loc_raddr),
        .loc_rdata    (loc_rdata),
        .sub_done     (sub_done),
        .pro_wen      (pro_wen),
        .pro_waddr    (pro_waddr),
        .pro_wdata    (pro_wdata),
        .pro_bytemask (pro_bytemask),
        .batch_finish (batch_finish),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          vid;
        logic [4:0]  own;
        int          na;
        int          pa;
        int          nb;
        int          pb;
        int          ninv;
        bit          self_bit;
        logic [7:0]  exp_word;
        bit          exp_mask;
    } vec_t;

    typedef struct {
        logic [BATCH_BW-1:0]  waddr;
        logic [Q*PRO_BW-1:0]  wdata;
        logic [Q-1:0]         mask;
    } exp_t;

    vec_t              vecs[8];
    exp_t              sb_q[$];
    logic [D-1:0]      adj[int];
    logic [LOC_BW-1:0] loc_tab[D];
    logic [VID_BW-1:0] lane_vid[Q];
    int                n_checks = 0;
    int                n_errors = 0;
    int                sub_cnt = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] dist_word(input logic [DIST_ADDR_BW-1:0] a);
        int v;
        int c;
        logic [D-1:0] row;
        v = int'(a) / C;
        c = int'(a) % C;
        if (!adj.exists(v)) return '0;
        row = adj[v];
        return row[c*W +: W];
    endfunction

    function automatic logic [W*LOC_BW-1:0] loc_word(input logic [$clog2(C)-1:0] c);
        logic [W*LOC_BW-1:0] r;
        for (int j = 0; j < W; j++) r[j*LOC_BW +: LOC_BW] = loc_tab[int'(c)*W + j];
        return r;
    endfunction

    // One-cycle-latency dist and loc SRAMs
    always @(posedge clk) begin
        dist_rdata <= dist_word(dist_raddr);
        loc_rdata  <= loc_word(loc_raddr);
    end

    // Returns {mask, target, gain} for one vertex over its whole row.
    function automatic logic [PRO_BW:0] model_lane(input int vid);
        int cnt[16];
        logic [D-1:0] row;
        logic [LOC_BW-1:0] own;
        logic [LOC_BW-1:0] e;
        int self_i, mx, cur, tgt, g;
        bit mv;
        self_i = vid % D;
        row = adj.exists(vid) ? adj[vid] : '0;
        for (int p = 0; p < 16; p++) cnt[p] = 0;
        for (int n = 0; n < D; n++) begin
            e = loc_tab[n];
            if (row[n] && e[4] && n != self_i) cnt[e[3:0]]++;
        end
        own = loc_tab[self_i];
        mx = 0;
        for (int p = 0; p < 16; p++) if (cnt[p] > mx) mx = cnt[p];
        cur = own[4] ? cnt[own[3:0]] : 0;
        tgt = 0;
        if (own[4] && cur == mx) tgt = int'(own[3:0]);
        else for (int p = 15; p >= 0; p--) if (cnt[p] == mx) tgt = p;
        g = mx - cur;
        if (g > 15) g = 15;
        mv = (mx > 0) && (!own[4] || tgt != int'(own[3:0]));
        return {mv, 4'(tgt), 4'(g)};
    endfunction

    task automatic setup_case(input vec_t v);
        logic [D-1:0] row;
        logic [D-1:0] r;
        int n;
        int cntg;
        adj.delete();
        for (int i = 0; i < D; i++) loc_tab[i] = LOC_BW'($urandom);
        row = '0;
        n = 0;
        for (int g = 0; g < 3; g++) begin
            cntg = (g == 0) ? v.na : (g == 1) ? v.nb : v.ninv;
            for (int k = 0; k < cntg; k++) begin
                if (n == v.vid % D) n++;
                row[n] = 1'b1;
                if (g == 0)      loc_tab[n] = {1'b1, 4'(v.pa)};
                else if (g == 1) loc_tab[n] = {1'b1, 4'(v.pb)};
                else             loc_tab[n] = {1'b0, 4'($urandom)};
                n++;
            end
        end
        loc_tab[v.vid % D] = v.own;
        if (v.self_bit) row[v.vid % D] = 1'b1;
        adj[v.vid] = row;
        lane_vid[0] = VID_BW'(v.vid);
        for (int q = 1; q < Q; q++) begin
            lane_vid[q] = VID_BW'(256 + $urandom_range(0, 3839));
            for (int k = 0; k < D / 32; k++) r[k*32 +: 32] = $urandom;
            adj[int'(lane_vid[q])] = r;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pro_wen"}, pro_wen, 0);
        chk({tag, "_batch_finish"}, batch_finish, 0);
        chk({tag, "_sub_done"}, sub_done, 0);
        chk({tag, "_pro_wdata"}, pro_wdata, 0);
        chk({tag, "_pro_bytemask"}, pro_bytemask, 0);
        chk({tag, "_pro_waddr"}, pro_waddr, 0);
        chk({tag, "_dist_raddr"}, dist_raddr, 0);
    endtask

    task automatic run_batch(input logic [BATCH_BW-1:0] bnum, input int stall_at, input int stall_len,
                             input bit en_at_start, input int busy_start_at);
        exp_t e;
        logic [PRO_BW:0] r;
        int cyc;
        bit seen;
        e.waddr = bnum;
        for (int q = 0; q < Q; q++) begin
            r = model_lane(int'(lane_vid[q]));
            e.wdata[q*PRO_BW +: PRO_BW] = r[PRO_BW-1:0];
            e.mask[q] = r[PRO_BW];
        end
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        batch_num = bnum;
        for (int q = 0; q < Q; q++) vid_rdata[q*VID_BW +: VID_BW] = lane_vid[q];
        en = en_at_start;
        sub_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        en = 1'b1;
        chk("busy_after_start", busy, 1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (pro_wen) seen = 1'b1;
            en = !(cyc >= stall_at && cyc < stall_at + stall_len);
            start = (cyc == busy_start_at);
            if (cyc == busy_start_at) begin
                batch_num = ~bnum;
                for (int q = 0; q < Q; q++) vid_rdata[q*VID_BW +: VID_BW] = VID_BW'($urandom);
            end
        end
        start = 1'b0;
        en = 1'b1;
        chk("pro_wen_seen", seen, 1);
        chk("latency", cyc, BASE_LAT + stall_len);
        chk("sub_done_count", sub_cnt, Q);
        @(negedge clk);
        chk("pro_wen_width", pro_wen, 0);
        chk("batch_finish_width", batch_finish, 0);
        repeat (2) @(negedge clk);
        chk("busy_after_write", busy, 0);
        chk("wdata_hold", pro_wdata, e.wdata);
        chk("bytemask_hold", pro_bytemask, e.mask);
    endtask

    // Scoreboard: compare every write against the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (sub_done) sub_cnt++;
        if (pro_wen) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pro_wen", pro_wen, 0);
            end else begin
                e = sb_q.pop_front();
                chk("pro_waddr", pro_waddr, e.waddr);
                chk("pro_wdata", pro_wdata, e.wdata);
                chk("pro_bytemask", pro_bytemask, e.mask);
                chk("batch_finish", batch_finish, 1);
            end
        end
    end

    initial begin
        int cyc;
        bit wen_seen;

        vecs[0] = '{5,   5'h17, 10,  3, 3, 7, 0, 1'b0, 8'h37, 1'b1};
        vecs[1] = '{5,   5'h16, 4,   2, 4, 6, 0, 1'b0, 8'h60, 1'b0};
        vecs[2] = '{5,   5'h19, 4,   2, 4, 6, 0, 1'b0, 8'h24, 1'b1};
        vecs[3] = '{9,   5'h14, 0,   0, 0, 0, 6, 1'b1, 8'h40, 1'b0};
        vecs[4] = '{0,   5'h10, 255, 1, 0, 0, 0, 1'b0, 8'h1F, 1'b1};
        vecs[5] = '{7,   5'h0B, 0,   0, 0, 0, 4, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{20,  5'h0C, 3,   5, 0, 0, 0, 1'b0, 8'h53, 1'b1};
        vecs[7] = '{100, 5'h13, 6,   3, 2, 8, 0, 1'b0, 8'h30, 1'b0};

        // Reset held with start asserted: must stay idle
        rst_n = 1'b0;
        start = 1'b1;
        batch_num = 8'hAA;
        vid_rdata = '1;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("reset");
        end
        start = 1'b0;
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            setup_case(vecs[i]);
            run_batch(BATCH_BW'(i + 1), -1, 0, 1'b1, -1);
            chk($sformatf("lane0_word_case%0d", i), pro_wdata[PRO_BW-1:0], vecs[i].exp_word);
            chk($sformatf("lane0_mask_case%0d", i), pro_bytemask[0], vecs[i].exp_mask);
        end

        // Five en-low cycles in the middle of vertex 2's stream
        setup_case(vecs[0]);
        run_batch(8'h40, 40, 5, 1'b1, -1);
        chk("stall_lane0_word", pro_wdata[PRO_BW-1:0], vecs[0].exp_word);
        chk("stall_lane0_mask", pro_bytemask[0], vecs[0].exp_mask);

        // start accepted even with en low in IDLE
        setup_case(vecs[1]);
        run_batch(8'h41, -1, 0, 1'b0, -1);
        chk("en_low_start_lane0_word", pro_wdata[PRO_BW-1:0], vecs[1].exp_word);

        // start pulse while busy must be ignored
        setup_case(vecs[2]);
        run_batch(8'h42, -1, 0, 1'b1, 50);
        chk("busy_start_lane0_word", pro_wdata[PRO_BW-1:0], vecs[2].exp_word);
        chk("busy_start_waddr", pro_waddr, 8'h42);

        // Reset pulse mid-batch aborts without a write
        setup_case(vecs[4]);
        @(negedge clk);
        start = 1'b1;
        batch_num = 8'h77;
        for (int q = 0; q < Q; q++) vid_rdata[q*VID_BW +: VID_BW] = lane_vid[q];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_in_reset", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wen_seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (pro_wen) wen_seen = 1'b1;
        end
        chk("abort_no_pro_wen", wen_seen, 0);
        check_idle_outputs("abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
